card_shoe: RTL and testbench
============================

# card_shoe

Finite-shoe card dealer for the Baccarat engine. It deals rank codes 1–13 (1 = A, 11 = J, 12 = Q, 13 = K) from a shoe holding DECKS standard decks and never deals a rank whose copies are exhausted. Each dealt card is presented on a 4-bit code with a valid/ack handshake. That code is the same encoding the 7-segment card display consumes, so `card` can drive a display digit directly.

## Interface
- DECKS, 1, decks in the shoe; legal range 1–8; each rank starts with 4·DECKS copies.
- clock  in  1  single clock; all state updates on the rising edge.
- resetb  in  1  synchronous, active-low reset.
- deal_req  in  1  request one card; sampled only in IDLE.
- shuffle  in  1  restore the full shoe; sampled only in IDLE.
- deal_ready  out  1  high in IDLE when the shoe is not empty.
- card  out  4  dealt rank code 1–13; 0 means blank.
- card_valid  out  1  `card` holds a dealt card awaiting ack.
- card_ack  in  1  consumer accepts the card; meaningful only while card_valid is high.
- cards_left  out  9  cards remaining in the shoe, 0 to 52·DECKS.
- shoe_empty  out  1  high exactly when cards_left == 0.

## Operation
- **Rank counter.** rank_ctr is free-running and advances every cycle in all states: 1 → 2 → … → 13 → 1. Reset value is 1.
- **Shoe state.** remaining[r] holds the copies left for each rank r = 1..13, reset to 4·DECKS. cards_left is reset to 52·DECKS.
- **FSM states:** IDLE, SEARCH, PRESENT. Reset enters IDLE.
- **IDLE**
  - shuffle = 1: every remaining[r] ← 4·DECKS and cards_left ← 52·DECKS. Stay in IDLE. A deal_req in the same cycle is ignored; shuffle wins.
  - else deal_req = 1 and shoe not empty: probe ← rank_ctr, go to SEARCH.
  - deal_req while shoe_empty: ignored, stay in IDLE.
- **SEARCH**, one probe per cycle:
  - remaining[probe] > 0: decrement it, decrement cards_left, card ← probe, card_valid ← 1, go to PRESENT.
  - otherwise: probe ← (probe == 13) ? 1 : probe + 1.
  - A non-empty shoe guarantees a hit within 13 probes.
- **PRESENT**
  - card and card_valid hold until card_ack = 1.
  - On ack: card_valid ← 0, go to IDLE. card keeps its value so the display persists.
  - deal_req and shuffle are ignored in PRESENT.
- **Ignored inputs.** deal_req, shuffle and card_ack are ignored outside their stated states.
- **Reset values:** card = 0, card_valid = 0, deal_ready = 1, cards_left = 52·DECKS, shoe_empty = 0.
- **Reset mid-operation.** Reset asserted in any state abandons the pending deal and restores the full shoe. The card in flight is not counted as dealt.
- **Arithmetic.** remaining uses 6 bits per rank. cards_left never underflows, because decrements occur only on a hit.

## Timing
- deal_req sampled high in IDLE at edge N → SEARCH during cycle N+1 → on an immediate hit, card_valid = 1 from edge N+2.
- Latency is 2 cycles minimum. If k ranks must be skipped, latency is 2 + k cycles, maximum 14.
- card_ack sampled high at edge M → card_valid = 0 and deal_ready = 1 (if not empty) from edge M+1.
- Throughput: at most one card per 3 cycles.
- deal_ready is registered, consistent with state and cards_left. It is low during SEARCH and PRESENT.
- shuffle takes effect at the next edge: cards_left = 52·DECKS one cycle after it is sampled.

## Configuration
- SHOE_SCORE_EN defined:
  - Adds output `card_score [3:0]`: the Baccarat value of the dealt card, registered together with `card`.
  - Ranks 1–9 map to themselves; ranks 10–13 map to 0.
  - Reset value is 0.
- SHOE_SCORE_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold resetb = 0 for 2 cycles → card = 0, card_valid = 0, deal_ready = 1, cards_left = 52, shoe_empty = 0.
- **Single deal:** DECKS = 1; rank_ctr is 1 in the first cycle after reset release. Assert deal_req when rank_ctr = 5 → card_valid rises 2 cycles later with card = 5 and cards_left = 51; it holds until ack and drops 1 cycle after ack.
- **Exhausted rank:** deal rank 5 four times, then request when rank_ctr = 5 → card = 6, valid 3 cycles after the request, remaining[5] = 0.
- **Wrap-around:** exhaust rank 13, then request when rank_ctr = 13 → card = 1 with 3-cycle latency.
- **Empty shoe and shuffle:** deal all 52 cards → shoe_empty = 1, cards_left = 0, deal_ready = 0, further deal_req ignored. Pulse shuffle → cards_left = 52 and deal_ready = 1 next cycle. Shuffle with deal_req in the same cycle → no deal.
- **Reset in PRESENT:** reset asserted in PRESENT → card_valid = 0, card = 0, cards_left = 52. With SHOE_SCORE_EN: a dealt rank 12 gives card_score = 0, a dealt rank 7 gives card_score = 7.

Source files
------------

// File: rtl/card_shoe.sv
// card_shoe: finite-shoe rank dealer with valid/ack handoff; optional SHOE_SCORE_EN adds card_score
module card_shoe #(
  parameter int DECKS = 1
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       deal_ready,
  output logic [3:0] card,
  output logic       card_valid,
  input  logic       card_ack,
  output logic [8:0] cards_left,
`ifdef SHOE_SCORE_EN
  output logic [3:0] card_score,
`endif
  output logic       shoe_empty
);
  localparam logic [5:0] per_rank = 6'(4 * DECKS);
  localparam logic [8:0] full_shoe = 9'(52 * DECKS);
  typedef enum logic [1:0] {IDLE, SEARCH, PRESENT} state_t;
  state_t state;
  logic [3:0] rank_ctr;
  logic [3:0] probe;
  logic [5:0] remaining [1:13];
  assign shoe_empty = cards_left == 9'd0;
  // free-running rank counter seeding where each search starts
  always_ff @(posedge clock)
    rank_ctr <= !resetb ? 4'd1 : (rank_ctr == 4'd13 ? 4'd1 : rank_ctr + 4'd1);
  // dealer FSM: idle/shuffle, linear probe for a non-exhausted rank, hold card until ack
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state <= IDLE;
      probe <= 4'd1;
      card <= 4'd0;
      card_valid <= 1'b0;
      deal_ready <= 1'b1;
      cards_left <= full_shoe;
`ifdef SHOE_SCORE_EN
      card_score <= 4'd0;
`endif
      for (int i = 1; i <= 13; i++) remaining[i] <= per_rank;
    end else begin
      case (state)
        IDLE:
          if (shuffle) begin
            for (int i = 1; i <= 13; i++) remaining[i] <= per_rank;
            cards_left <= full_shoe;
            deal_ready <= 1'b1;
          end else if (deal_req && cards_left != 9'd0) begin
            probe <= rank_ctr;
            state <= SEARCH;
            deal_ready <= 1'b0;
          end
        SEARCH:
          if (remaining[probe] != 6'd0) begin
            remaining[probe] <= remaining[probe] - 6'd1;
            cards_left <= cards_left - 9'd1;
            card <= probe;
`ifdef SHOE_SCORE_EN
            card_score <= probe <= 4'd9 ? probe : 4'd0;
`endif
            card_valid <= 1'b1;
            state <= PRESENT;
          end else begin
            probe <= probe == 4'd13 ? 4'd1 : probe + 4'd1;
          end
        PRESENT:
          if (card_ack) begin
            card_valid <= 1'b0;
            deal_ready <= cards_left != 9'd0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed self-checking bench for card_shoe with DECKS = 1
module tb_card_shoe;
  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       deal_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       card_ack = 1'b0;
  logic       deal_ready;
  logic [3:0] card;
  logic       card_valid;
  logic [8:0] cards_left;
  logic       shoe_empty;
`ifdef SHOE_SCORE_EN
  logic [3:0] card_score;
`endif
  int checks = 0;
  int fails = 0;
  int exp_rank = 1;
  int exp_left = 52;
  int rem [1:13];
  int last_card;
  int last_lat;

  card_shoe #(.DECKS(1)) dut (
    .clock(clock), .resetb(resetb), .deal_req(deal_req), .shuffle(shuffle),
    .deal_ready(deal_ready), .card(card), .card_valid(card_valid), .card_ack(card_ack),
    .cards_left(cards_left),
`ifdef SHOE_SCORE_EN
    .card_score(card_score),
`endif
    .shoe_empty(shoe_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    exp_rank = !resetb ? 1 : (exp_rank == 13 ? 1 : exp_rank + 1);
  endtask

  task automatic wait_rank(input int r);
    while (exp_rank != r) tick();
  endtask

  task automatic refill();
    for (int i = 1; i <= 13; i++) rem[i] = 4;
    exp_left = 52;
  endtask

  task automatic deal();
    int p;
    int k;
    int n;
    p = exp_rank;
    k = 0;
    while (rem[p] == 0) begin
      p = p == 13 ? 1 : p + 1;
      k++;
    end
    rem[p]--;
    exp_left--;
    deal_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      deal_req = 1'b0;
    end while (!card_valid && n < 20);
    last_card = card;
    last_lat = n;
    check("deal_card", card, p);
    check("deal_latency", n, 2 + k);
    check("deal_left", cards_left, exp_left);
    tick();
    check("valid_hold", card_valid, 1);
    card_ack = 1'b1;
    tick();
    card_ack = 1'b0;
    check("valid_drop", card_valid, 0);
    check("card_persist", card, p);
    check("ready_after_ack", deal_ready, exp_left != 0 ? 1 : 0);
  endtask

  initial begin
    refill();
    tick();
    tick();
    check("rst_card", card, 0);
    check("rst_valid", card_valid, 0);
    check("rst_ready", deal_ready, 1);
    check("rst_left", cards_left, 52);
    check("rst_empty", shoe_empty, 0);
    resetb = 1'b1;
    // single deal at rank 5
    wait_rank(5);
    deal();
    check("single_card5", last_card, 5);
    check("single_lat2", last_lat, 2);
    check("single_left51", cards_left, 51);
    // exhaust rank 5 then request at 5
    for (int i = 0; i < 3; i++) begin
      wait_rank(5);
      deal();
    end
    wait_rank(5);
    deal();
    check("exhaust_card6", last_card, 6);
    check("exhaust_lat3", last_lat, 3);
    // exhaust rank 13 then wrap to ace
    for (int i = 0; i < 4; i++) begin
      wait_rank(13);
      deal();
    end
    wait_rank(13);
    deal();
    check("wrap_card1", last_card, 1);
    check("wrap_lat3", last_lat, 3);
    check("wrap_left42", cards_left, 42);
    // drain the shoe
    while (exp_left > 0) deal();
    check("empty_flag", shoe_empty, 1);
    check("empty_left", cards_left, 0);
    check("empty_ready", deal_ready, 0);
    deal_req = 1'b1;
    tick();
    tick();
    tick();
    deal_req = 1'b0;
    check("empty_req_valid", card_valid, 0);
    check("empty_req_left", cards_left, 0);
    // shuffle restores the shoe
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    refill();
    check("shuffle_left", cards_left, 52);
    check("shuffle_ready", deal_ready, 1);
    check("shuffle_empty", shoe_empty, 0);
    deal();
    check("post_shuffle_left", cards_left, 51);
    shuffle = 1'b1;
    deal_req = 1'b1;
    tick();
    shuffle = 1'b0;
    deal_req = 1'b0;
    refill();
    check("shuf_wins_left", cards_left, 52);
    tick();
    tick();
    check("shuf_wins_valid", card_valid, 0);
    check("shuf_wins_ready", deal_ready, 1);
`ifdef SHOE_SCORE_EN
    wait_rank(12);
    deal();
    check("score_rank12", card_score, 0);
    wait_rank(7);
    deal();
    check("score_rank7", card_score, 7);
`endif
    // reset while presenting
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    tick();
    check("pre_rst_valid", card_valid, 1);
    resetb = 1'b0;
    tick();
    check("midrst_valid", card_valid, 0);
    check("midrst_card", card, 0);
    check("midrst_left", cards_left, 52);
    check("midrst_ready", deal_ready, 1);
    resetb = 1'b1;
    refill();
    wait_rank(3);
    deal();
    check("after_rst_card3", last_card, 3);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
